// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button event decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package button_pkg;

    // Decoder FSM states.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HELD        = 3'd2,
        LONG_HELD   = 3'd3,
        DEB_RELEASE = 3'd4
    } btn_state_t;

    // Defaults for a 50 MHz clock: 20 ms debounce window, 1 s long press.
    localparam int BTN_DEBOUNCE_50M = 1_000_000;
    localparam int BTN_LONG_50M     = 50_000_000;

endpackage

// File: rtl/btn_sync2.sv
// Polarity-corrects the raw button pin and brings it into the clock domain with two flops.
// Latency: 2 clocks from pin change to Btn_Sync.
// Backpressure: none; free-running sampler.
//
// Ports:
//   Clk_50MHz   - system clock
//   Rst_OnBoard - async active-low reset; both flops clear to "not pressed"
//   Btn_Raw     - asynchronous button pin
//   Btn_Sync    - synchronised pressed level (1 = pressed)
module btn_sync2 #(
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic Clk_50MHz,
    input  logic Rst_OnBoard,
    input  logic Btn_Raw,
    output logic Btn_Sync
);

    logic pressed_raw;
    logic meta_q;

    // Fold polarity in before the first flop so both stages reset to "not pressed".
    assign pressed_raw = BTN_ACTIVE_LOW ? ~Btn_Raw : Btn_Raw;

    always_ff @(posedge Clk_50MHz or negedge Rst_OnBoard) begin
        if (!Rst_OnBoard) begin
            meta_q   <= 1'b0;
            Btn_Sync <= 1'b0;
        end else begin
            meta_q   <= pressed_raw;
            Btn_Sync <= meta_q;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Debounces a raw push-button and classifies presses as short (pulse on release) or long (pulse at hold threshold).
// Latency: level/short pulse DEBOUNCE_CYCLES+3 clocks after a stable pin edge; long pulse LONG_PRESS_CYCLES after level rise.
// Backpressure: none; pulses are single-cycle and must be consumed when emitted.
//
// Ports:
//   Clk_50MHz   - system clock
//   Rst_OnBoard - async active-low reset
//   Btn_Raw     - raw bouncing button pin
//   Btn_Level   - debounced pressed level
//   Short_Pulse - one cycle on release of a short press
//   Long_Pulse  - one cycle when a hold reaches LONG_PRESS_CYCLES
//   Mode_Sel    - toggles per short press, cleared by a long press
//   Press_Count - accepted short presses, wraps 255->0
module button_event_decoder
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = BTN_DEBOUNCE_50M,
    parameter int LONG_PRESS_CYCLES = BTN_LONG_50M,
    parameter bit BTN_ACTIVE_LOW    = 1'b1,
    parameter int CNT_W             = 26
) (
    input  logic       Clk_50MHz,
    input  logic       Rst_OnBoard,
    input  logic       Btn_Raw,
    output logic       Btn_Level,
    output logic       Short_Pulse,
    output logic       Long_Pulse,
    output logic       Mode_Sel,
    output logic [7:0] Press_Count
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    btn_state_t       state;
    logic [CNT_W-1:0] dcnt;
    logic [CNT_W-1:0] hcnt;
    logic             long_flag;
    logic             btn_s;

    btn_sync2 #(
        .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
    ) u_sync (
        .Clk_50MHz   (Clk_50MHz),
        .Rst_OnBoard (Rst_OnBoard),
        .Btn_Raw     (Btn_Raw),
        .Btn_Sync    (btn_s)
    );

    always_ff @(posedge Clk_50MHz or negedge Rst_OnBoard) begin
        if (!Rst_OnBoard) begin
            state       <= IDLE;
            dcnt        <= '0;
            hcnt        <= '0;
            long_flag   <= 1'b0;
            Btn_Level   <= 1'b0;
            Short_Pulse <= 1'b0;
            Long_Pulse  <= 1'b0;
            Mode_Sel    <= 1'b0;
            Press_Count <= 8'd0;
        end else begin
            Short_Pulse <= 1'b0;
            Long_Pulse  <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= DEB_PRESS;
                        dcnt  <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (dcnt == DEB_LAST) begin
                        state     <= HELD;
                        Btn_Level <= 1'b1;
                        hcnt      <= '0;
                    end else begin
                        dcnt <= dcnt + CNT_ONE;
                    end
                end
                HELD: begin
                    // hcnt is left untouched on a release glitch so a
                    // bounce only stretches the hold, never restarts it.
                    if (!btn_s) begin
                        state <= DEB_RELEASE;
                        dcnt  <= '0;
                    end else if (hcnt == LONG_LAST) begin
                        state      <= LONG_HELD;
                        Long_Pulse <= 1'b1;
                        Mode_Sel   <= 1'b0;
                        long_flag  <= 1'b1;
                    end else begin
                        hcnt <= hcnt + CNT_ONE;
                    end
                end
                LONG_HELD: begin
                    if (!btn_s) begin
                        state <= DEB_RELEASE;
                        dcnt  <= '0;
                    end
                end
                DEB_RELEASE: begin
                    if (btn_s) begin
                        state <= long_flag ? LONG_HELD : HELD;
                    end else if (dcnt == DEB_LAST) begin
                        state     <= IDLE;
                        Btn_Level <= 1'b0;
                        long_flag <= 1'b0;
                        if (!long_flag) begin
                            Short_Pulse <= 1'b1;
                            Mode_Sel    <= ~Mode_Sel;
                            Press_Count <= Press_Count + 8'd1;
                        end
                    end else begin
                        dcnt <= dcnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder with a pulse scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_event_decoder;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int LAT = DEB + 3;   // pin edge to registered output

    logic       Clk_50MHz   = 1'b0;
    logic       Rst_OnBoard = 1'b1;
    logic       Btn_Raw     = 1'b1;
    logic       Btn_Level;
    logic       Short_Pulse;
    logic       Long_Pulse;
    logic       Mode_Sel;
    logic [7:0] Press_Count;

    always #10 Clk_50MHz = ~Clk_50MHz;

    button_event_decoder #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LNG),
        .BTN_ACTIVE_LOW    (1'b1),
        .CNT_W             (26)
    ) dut (
        .Clk_50MHz   (Clk_50MHz),
        .Rst_OnBoard (Rst_OnBoard),
        .Btn_Raw     (Btn_Raw),
        .Btn_Level   (Btn_Level),
        .Short_Pulse (Short_Pulse),
        .Long_Pulse  (Long_Pulse),
        .Mode_Sel    (Mode_Sel),
        .Press_Count (Press_Count)
    );

    typedef struct {
        bit         is_long;
        int         cyc;
        logic       mode;
        logic [7:0] cnt;
    } ev_t;

    ev_t        sb[$];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       exp_mode = 1'b0;
    logic [7:0] exp_cnt  = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_ev(input bit is_long, input int at);
        ev_t e;
        e.is_long = is_long;
        e.cyc     = at;
        e.mode    = exp_mode;
        e.cnt     = exp_cnt;
        sb.push_back(e);
    endtask

    // One clock; outputs sampled 1 time unit after the edge and any pulse
    // is matched against the oldest expected event.
    task automatic tick();
        ev_t e;
        @(posedge Clk_50MHz);
        cyc++;
        #1;
        if (Short_Pulse || Long_Pulse) begin
            chk("pulse_exclusive", 32'(Short_Pulse & Long_Pulse), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {30'd0, Long_Pulse, Short_Pulse}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind",  32'(Long_Pulse), 32'(e.is_long));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                chk("pulse_mode",  32'(Mode_Sel), 32'(e.mode));
                chk("pulse_count", 32'(Press_Count), 32'(e.cnt));
            end
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {27'd0, Btn_Level, Short_Pulse, Long_Pulse, Mode_Sel, 1'b0}, 32'd0);
        chk({tag, "_count"}, 32'(Press_Count), 32'd0);
    endtask

    // Pin held low for n clocks (n >= LAT), then released cleanly.
    task automatic short_press(input int n);
        int c0;
        c0 = cyc;
        Btn_Raw  = 1'b0;
        exp_mode = ~exp_mode;
        exp_cnt  = exp_cnt + 8'd1;
        push_ev(1'b0, c0 + n + LAT);
        run_to(c0 + LAT - 1);
        chk("level_before_rise", 32'(Btn_Level), 32'd0);
        tick();
        chk("level_rise", 32'(Btn_Level), 32'd1);
        run_to(c0 + n);
        Btn_Raw = 1'b1;
        run_to(c0 + n + LAT - 1);
        chk("level_before_fall", 32'(Btn_Level), 32'd1);
        tick();
        chk("level_fall", 32'(Btn_Level), 32'd0);
        tick();
        tick();
    endtask

    // Long hold; optional release bounce of blen clocks at offset bat.
    // A bounce of blen clocks costs blen+1 edges of hold counting.
    task automatic long_press(input int n_hold, input int bat, input int blen);
        int c0;
        int lo;
        c0 = cyc;
        lo = 0;
        Btn_Raw  = 1'b0;
        exp_mode = 1'b0;
        push_ev(1'b1, c0 + LAT + LNG + ((blen > 0) ? blen + 1 : 0));
        run_to(c0 + LAT);
        chk("long_level_rise", 32'(Btn_Level), 32'd1);
        while (cyc < c0 + n_hold) begin
            if (blen > 0 && cyc == c0 + bat)        Btn_Raw = 1'b1;
            if (blen > 0 && cyc == c0 + bat + blen) Btn_Raw = 1'b0;
            tick();
            if (Btn_Level !== 1'b1) lo++;
        end
        chk("level_steady_hold", 32'(lo), 32'd0);
        Btn_Raw = 1'b1;
        run_to(c0 + n_hold + LAT);
        chk("long_level_fall", 32'(Btn_Level), 32'd0);
        chk("long_mode", 32'(Mode_Sel), 32'd0);
        chk("long_count", 32'(Press_Count), 32'(exp_cnt));
        tick();
        tick();
    endtask

    initial begin
        int c0;
        int hi;

        // Reset held with the button idle.
        Btn_Raw     = 1'b1;
        Rst_OnBoard = 1'b0;
        repeat (10) tick();
        chk_all_zero("in_reset");
        Rst_OnBoard = 1'b1;
        repeat (50) tick();
        chk_all_zero("after_reset");

        // Two-clock glitch: shorter than the debounce window.
        c0 = cyc;
        hi = 0;
        Btn_Raw = 1'b0;
        while (cyc < c0 + 20) begin
            if (cyc == c0 + 2) Btn_Raw = 1'b1;
            tick();
            if (Btn_Level !== 1'b0) hi++;
        end
        chk("glitch_level", 32'(hi), 32'd0);
        chk("glitch_count", 32'(Press_Count), 32'd0);

        // Short presses: mode toggles, count advances.
        short_press(10);
        chk("short1_mode", 32'(Mode_Sel), 32'd1);
        chk("short1_count", 32'(Press_Count), 32'd1);
        short_press(10);
        chk("short2_mode", 32'(Mode_Sel), 32'd0);
        chk("short2_count", 32'(Press_Count), 32'd2);
        short_press(10);
        chk("short3_mode", 32'(Mode_Sel), 32'd1);

        // Long press from Mode_Sel=1, then one with a release bounce.
        long_press(40, 0, 0);
        long_press(45, 10, 2);
        chk("sb_after_long", 32'(sb.size()), 32'd0);

        // Async reset while HELD, button kept pressed through reset.
        short_press(8);
        c0 = cyc;
        Btn_Raw = 1'b0;
        run_to(c0 + 12);
        chk("held_before_reset", 32'(Btn_Level), 32'd1);
        #2;
        Rst_OnBoard = 1'b0;
        #1;
        chk_all_zero("async_reset");
        exp_mode = 1'b0;
        exp_cnt  = 8'd0;
        repeat (3) tick();
        Rst_OnBoard = 1'b1;
        c0 = cyc;
        run_to(c0 + LAT - 1);
        chk("fresh_before_rise", 32'(Btn_Level), 32'd0);
        tick();
        chk("fresh_rise", 32'(Btn_Level), 32'd1);
        chk("fresh_count_zero", 32'(Press_Count), 32'd0);
        run_to(c0 + 10);
        exp_mode = 1'b1;
        exp_cnt  = 8'd1;
        push_ev(1'b0, c0 + 10 + LAT);
        Btn_Raw = 1'b1;
        run_to(c0 + 10 + LAT + 2);
        chk("fresh_short_count", 32'(Press_Count), 32'd1);

        // Clean reset, then 256 short presses to wrap the counter.
        Rst_OnBoard = 1'b0;
        repeat (3) tick();
        Rst_OnBoard = 1'b1;
        exp_mode = 1'b0;
        exp_cnt  = 8'd0;
        repeat (3) tick();
        chk_all_zero("pre_wrap");
        for (int i = 0; i < 256; i++) short_press(8);
        chk("wrap_count", 32'(Press_Count), 32'd0);
        chk("wrap_mode", 32'(Mode_Sel), 32'd0);

        repeat (10) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
